// File: rtl/sr32_load_ctrl_pkg.sv
// Shared types and constants for the 32-bit shift-register load controller.
package sr32_ctrl_pkg;

  // Default chain length in bits.
  localparam int SR_WIDTH = 32;

  // Bit-count register width: must hold the value SR_WIDTH itself.
  localparam int CNT_W = $clog2(SR_WIDTH + 1);

  // Latch-hold counter width (LATCH_CYCLES is 1..15).
  localparam int LCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sr32_load_ctrl_if.sv
// Host-side word handshake plus the serial chain control lines.
//
// Handshake: a word transfers on a rising clk edge when valid=1, ready=1
// and clear=0. ready is a pure state decode, so it never depends on valid
// in the same cycle. valid may rise or fall at any time, and data is
// sampled only on the transfer edge.
interface sr32_load_ctrl_if
  import sr32_ctrl_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             clear;
  logic             sr_d;
  logic             sr_shift;
  logic             sr_clr;
  logic             latch;
  logic             done;
  logic             busy;

  // Host / register-interface side.
  modport master (
    output data, valid, clear,
    input  ready, sr_d, sr_shift, sr_clr, latch, done, busy
  );

  // Controller side.
  modport slave (
    input  data, valid, clear,
    output ready, sr_d, sr_shift, sr_clr, latch, done, busy
  );
endinterface

// File: rtl/sr32_load_ctrl_piso.sv
// Parallel-in serial-out holding register. It loads a word, shifts it toward
// the emitted end one bit per shift and fills the vacated end with zeros, so
// the serial output is 0 once a word has been fully emitted.
module sr32_piso
  import sr32_ctrl_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] hold;

  // Holding register: clear beats load, and load beats shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= '0;
    end else if (clr) begin
      hold <= '0;
    end else if (load) begin
      hold <= din;
    end else if (shift) begin
      if (MSB_FIRST != 0) hold <= {hold[WIDTH-2:0], 1'b0};
      else                hold <= {1'b0, hold[WIDTH-1:1]};
    end
  end

  assign sout = (MSB_FIRST != 0) ? hold[WIDTH-1] : hold[0];

endmodule

// File: rtl/sr32_load_ctrl.sv
// Loads one parallel word into the serial chain, one bit per cycle, then
// holds the latch strobe and reports completion with a one-cycle done pulse.
// All chain and status outputs come straight from flops.
module sr32_load_ctrl
  import sr32_ctrl_pkg::*;
#(
  parameter int WIDTH        = SR_WIDTH,
  parameter int MSB_FIRST    = 1,
  parameter int LATCH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  sr32_load_ctrl_if.slave bus,
  output state_t          state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t            state, state_n;
  logic [CW-1:0]     count, count_n;
  logic [LCNT_W-1:0] lcnt, lcnt_n;
  logic              hold_load, hold_shift, hold_clr;
  logic              clear_d;
  logic              ready_q, busy_q, shift_q, clr_q, latch_q, done_q;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      lcnt  <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      lcnt  <= lcnt_n;
    end
  end

  // Next state, counters and holding-register controls. Clear overrides
  // everything, including an accept in IDLE.
  always_comb begin
    state_n    = state;
    count_n    = count;
    lcnt_n     = lcnt;
    hold_load  = 1'b0;
    hold_shift = 1'b0;
    hold_clr   = 1'b0;
    if (bus.clear) begin
      state_n  = IDLE;
      count_n  = '0;
      lcnt_n   = '0;
      hold_clr = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid) begin
            hold_load = 1'b1;
            count_n   = CW'(WIDTH);
            state_n   = SHIFT;
          end
        end
        SHIFT: begin
          hold_shift = 1'b1;
          if (count == CW'(1)) begin
            count_n = '0;
            lcnt_n  = LCNT_W'(LATCH_CYCLES);
            state_n = LATCH;
          end else begin
            count_n = count - CW'(1);
          end
        end
        LATCH: begin
          if (lcnt == LCNT_W'(1)) begin
            lcnt_n  = '0;
            state_n = DONE;
          end else begin
            lcnt_n = lcnt - LCNT_W'(1);
          end
        end
        DONE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Registered strobes. Each one is a decode of the state being entered, so
  // it lines up exactly with that state. The clear pulse fires only on the
  // rising edge of clear, so a held clear gives a single pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      shift_q <= 1'b0;
      clr_q   <= 1'b0;
      latch_q <= 1'b0;
      done_q  <= 1'b0;
      clear_d <= 1'b0;
    end else begin
      ready_q <= (state_n == IDLE);
      busy_q  <= (state_n != IDLE);
      shift_q <= (state_n == SHIFT);
      latch_q <= (state_n == LATCH);
      done_q  <= (state_n == DONE);
      clr_q   <= bus.clear & ~clear_d;
      clear_d <= bus.clear;
    end
  end

  sr32_piso #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (hold_load),
    .shift (hold_shift),
    .clr   (hold_clr),
    .din   (bus.data),
    .sout  (bus.sr_d)
  );

  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.sr_shift = shift_q;
  assign bus.sr_clr   = clr_q;
  assign bus.latch    = latch_q;
  assign bus.done     = done_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_sr32_load_ctrl.sv
// Bench for sr32_load_ctrl. Unit 0 is MSB-first with a 1-cycle latch, and
// unit 1 is LSB-first with a 3-cycle latch. A negedge monitor rebuilds each
// chain from sr_d/sr_shift and scores the chain contents at the first latch
// cycle against the word queued at accept time.
module tb_sr32_load_ctrl;
  import sr32_ctrl_pkg::*;

  localparam int LC_A = 1;
  localparam int LC_B = 3;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [31:0] exp_q[$];

  sr32_load_ctrl_if #(.WIDTH(32)) ifa ();
  sr32_load_ctrl_if #(.WIDTH(32)) ifb ();
  state_t st [2];

  sr32_load_ctrl #(.WIDTH(32), .MSB_FIRST(1), .LATCH_CYCLES(LC_A)) dut_a (
    .clk(clk), .reset(rst), .bus(ifa), .state_dbg(st[0])
  );
  sr32_load_ctrl #(.WIDTH(32), .MSB_FIRST(0), .LATCH_CYCLES(LC_B)) dut_b (
    .clk(clk), .reset(rst), .bus(ifb), .state_dbg(st[1])
  );

  logic [1:0] sh, sd, lt, dn, rd, by, sc, vl, cl;
  logic [31:0] dat [2];
  assign sh = {ifb.sr_shift, ifa.sr_shift};
  assign sd = {ifb.sr_d, ifa.sr_d};
  assign lt = {ifb.latch, ifa.latch};
  assign dn = {ifb.done, ifa.done};
  assign rd = {ifb.ready, ifa.ready};
  assign by = {ifb.busy, ifa.busy};
  assign sc = {ifb.sr_clr, ifa.sr_clr};
  assign vl = {ifb.valid, ifa.valid};
  assign cl = {ifb.clear, ifa.clear};
  assign dat[0] = ifa.data;
  assign dat[1] = ifb.data;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_idle(input int u, input string tag);
    check(tag, {st[u], rd[u], by[u], sh[u], sd[u], lt[u], dn[u], sc[u]}, {IDLE, 7'b1000000});
  endtask

  // Expected {state, ready, busy, sr_shift, sr_d, latch, done} on cycle c
  // after the accept edge (c=1 is the first cycle after it).
  function automatic logic [7:0] exp_vec(input int u, input int c, input logic [31:0] d);
    int   lc;
    logic b;
    lc = (u == 0) ? LC_A : LC_B;
    if (c >= 1 && c <= 32) begin
      b = (u == 0) ? d[32 - c] : d[c - 1];
      return {SHIFT, 1'b0, 1'b1, 1'b1, b, 1'b0, 1'b0};
    end
    if (c >= 33 && c <= 32 + lc) return {LATCH, 6'b010010};
    if (c == 33 + lc)            return {DONE,  6'b010001};
    return {IDLE, 6'b100000};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int          cyc      [2];
  bit          active   [2];
  bit          exp_sc   [2];
  bit          cl_last  [2];
  logic [31:0] chain    [2];
  logic [31:0] cur      [2];

  initial begin
    for (int u = 0; u < 2; u++) begin
      cyc[u] = 0; active[u] = 0; exp_sc[u] = 0; cl_last[u] = 0;
      chain[u] = '0; cur[u] = '0;
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst) begin
        if (active[u] && exp_q.size() > 0) exp_q.delete(0);
        active[u]  = 0;
        exp_sc[u]  = 0;
        cl_last[u] = 0;
      end else begin
        if (sc[u] || exp_sc[u]) check($sformatf("u%0d_sr_clr", u), sc[u], exp_sc[u]);
        if (sc[u]) chain[u] = '0;
        if (sh[u]) begin
          if (u == 0) chain[u] = {chain[u][30:0], sd[u]};
          else        chain[u] = {sd[u], chain[u][31:1]};
        end
        exp_sc[u]  = cl[u] && !cl_last[u];
        cl_last[u] = cl[u];
        if (active[u]) begin
          cyc[u]++;
          check($sformatf("u%0d_cyc%0d", u, cyc[u]),
                {st[u], rd[u], by[u], sh[u], sd[u], lt[u], dn[u]},
                exp_vec(u, cyc[u], cur[u]));
          if (cyc[u] == 33) begin
            if (exp_q.size() == 0) begin
              check($sformatf("u%0d_sb_empty", u), 1, 0);
            end else begin
              check($sformatf("u%0d_chain", u), chain[u], exp_q[0]);
              exp_q.delete(0);
            end
          end
          if (cyc[u] == 34 + ((u == 0) ? LC_A : LC_B)) begin
            active[u] = 0;
          end else if (cl[u]) begin
            if (cyc[u] < 33 && exp_q.size() > 0) exp_q.delete(0);
            active[u] = 0;
          end
        end
        if (!active[u] && vl[u] && rd[u] && !cl[u]) begin
          active[u] = 1;
          cyc[u]    = 0;
          cur[u]    = dat[u];
          exp_q.push_back(dat[u]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int u, input logic v, input logic c, input logic [31:0] d);
    if (u == 0) begin ifa.valid = v; ifa.clear = c; ifa.data = d; end
    else        begin ifb.valid = v; ifb.clear = c; ifb.data = d; end
  endtask

  // Presents one word for a single cycle; the unit must be idle.
  task automatic send(input int u, input logic [31:0] d);
    @(posedge clk); #1;
    drive(u, 1'b1, 1'b0, d);
    @(posedge clk); #1;
    drive(u, 1'b0, 1'b0, $urandom());
  endtask

  task automatic wait_done(input int u, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dn[u]) begin got = 1'b1; break; end
    end
    check($sformatf("u%0d_done_seen", u), got, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses, shifts, nrdy, bad;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    drive(0, 0, 0, '0);
    drive(1, 0, 0, '0);
    #1 rst = 1'b0;

    // Reset held three cycles, then ten idle cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle(0, "idle_a");
    end
    check_idle(1, "idle_b");

    // Single MSB-first load.
    send(0, 32'hA5C3_0F81);
    wait_done(0, 60);
    repeat (3) @(negedge clk);

    // LSB-first, 3-cycle latch.
    send(1, 32'h0000_0001);
    wait_done(1, 60);
    repeat (3) @(negedge clk);

    // Back-to-back with valid held; data changes during the first shift.
    @(posedge clk); #1 drive(0, 1, 0, 32'hFFFF_FFFF);
    @(posedge clk); #1 drive(0, 1, 0, 32'h0000_0000);
    wait_done(0, 60);
    @(posedge clk);
    @(posedge clk); #1 drive(0, 0, 0, 32'h0);
    wait_done(0, 60);
    repeat (3) @(negedge clk);

    // Clear during shift cycle 10, then a clean reload.
    send(0, 32'h1234_5678);
    repeat (9) @(posedge clk);
    #1 drive(0, 0, 1, 32'h0);
    @(posedge clk); #1 drive(0, 0, 0, 32'h0);
    @(negedge clk);
    check("clr_shift", {st[0], rd[0], by[0], sh[0], sd[0], lt[0], dn[0], sc[0]}, {IDLE, 7'b1000001});
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (lt[0] || dn[0] || sh[0] || sc[0] || !rd[0]) bad++;
    end
    check("clr_quiet", bad, 0);
    send(0, 32'hDEAD_BEEF);
    wait_done(0, 60);
    repeat (3) @(negedge clk);

    // Clear and valid together in IDLE, clear held three cycles.
    @(posedge clk); #1 drive(0, 1, 1, 32'hCAFE_F00D);
    pulses = 0; shifts = 0; nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) drive(0, 0, 0, 32'h0);
      @(negedge clk);
      if (i == 0)
        check("clr_idle", {st[0], rd[0], by[0], sh[0], lt[0], dn[0], sc[0]}, {IDLE, 6'b100001});
      pulses += int'(sc[0]);
      shifts += int'(sh[0]);
      nrdy   += int'(!rd[0]);
    end
    check("clr_held_pulses", pulses, 1);
    check("clr_held_noshift", {shifts[15:0], nrdy[15:0]}, 32'h0);

    // Async reset in shift cycle 5.
    send(0, $urandom());
    repeat (4) @(posedge clk);
    #1 check("pre_rst_shift", {by[0], sh[0]}, 2'b11);
    #1 rst = 1'b0;
    #1 check_idle(0, "async_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_idle(0, "post_rst");

    // A few random words after recovery.
    for (int k = 0; k < 3; k++) begin
      send(k % 2, $urandom());
      wait_done(k % 2, 60);
      repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("sb_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
